// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types and constants for the ALU arbiter slice.
//   - aluop_e      : 4-bit ALU opcode encoding (ADD=0 .. SRA=9)
//   - NUM_ALU_OPS  : number of legal opcodes; anything at or above is illegal
//   - DEFAULT_XLEN : default operand/result width
//   - is_legal_op  : opcode legality helper
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_OR   = 4'd2,
      ALU_XOR  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } aluop_e;

   localparam int unsigned NUM_ALU_OPS  = 10;
   localparam int unsigned DEFAULT_XLEN = 32;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op < 4'(NUM_ALU_OPS));
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_core
//   Combinational integer ALU shared by the arbiter.
//   Ports:
//     a_i      [XLEN-1:0] operand 1
//     b_i      [XLEN-1:0] operand 2 (arithmetic/logic ops)
//     shamt_i  [4:0]      pre-masked shift amount
//     op_i     [3:0]      opcode (aluop_e); illegal codes yield 0
//     result_o [XLEN-1:0] result
// -----------------------------------------------------------------------------
module alu_core
   import alu_arb_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      shamt_i,
   input  logic [3:0]      op_i,
   output logic [XLEN-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         ALU_SLL:  result_o = a_i << shamt_i;
         ALU_SRL:  result_o = a_i >> shamt_i;
         ALU_SRA:  result_o = XLEN'($signed(a_i) >>> shamt_i);
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant selection. The pointer register lives in
//   the parent; this block only searches from ptr_i+1 with wrap-around.
//   Ports:
//     req_i     [NUM_REQ-1:0] request vector
//     advance_i               grant enable (downstream can accept)
//     ptr_i     [ID_W-1:0]    index of the last granted requester
//     grant_o   [NUM_REQ-1:0] one-hot grant, zero when no request/advance
//     idx_o     [ID_W-1:0]    encoded index of the winning requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               advance_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o
);

   logic        found;
   int unsigned cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      // Offsets 1..NUM_REQ visit every index once, ending at the pointer itself,
      // so a lone persistent requester is still found.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(ptr_i) + k) % NUM_REQ;
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = ID_W'(cand);
         end
      end
      if (found && advance_i) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin shares one combinational ALU between NUM_REQ requesters and
//   returns results through a single registered response slot tagged with the
//   requester ID (1-cycle service latency).
//   Optional feature macro: ALU_ARBITER_ERR_EN (adds resp_err for illegal ops).
//   Ports:
//     clk, rst                       clock, async active-high reset
//     req_valid  [NUM_REQ-1:0]       request valid per requester
//     req_ready  [NUM_REQ-1:0]       request accept, one-hot or zero
//     req_op1    [NUM_REQ*XLEN-1:0]  packed operand 1 (slice i = requester i)
//     req_op2    [NUM_REQ*XLEN-1:0]  packed operand 2
//     req_aluop  [NUM_REQ*4-1:0]     packed 4-bit opcode
//     resp_valid                     response slot occupied
//     resp_ready                     consumer accepts response
//     resp_id    [ID_W-1:0]          owner of resp_result
//     resp_result[XLEN-1:0]          ALU result
//     resp_err                       (ALU_ARBITER_ERR_EN only) illegal opcode
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = DEFAULT_XLEN,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_op1,
   input  logic [NUM_REQ*XLEN-1:0] req_op2,
   input  logic [NUM_REQ*4-1:0]    req_aluop,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [XLEN-1:0]         resp_result
`ifdef ALU_ARBITER_ERR_EN
   ,
   output logic                    resp_err
`endif
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            resp_valid_q, resp_valid_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic [XLEN-1:0] resp_result_q, resp_result_d;

   logic            can_accept;
   logic            advance;
   logic            xfer;
   logic [ID_W-1:0] win_idx;
   logic [XLEN-1:0] sel_op1;
   logic [XLEN-1:0] sel_op2;
   logic [3:0]      sel_op;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_result;

   // Slot frees up in the same cycle it drains, so issue can continue back-to-back.
   assign can_accept = !resp_valid_q || resp_ready;
   assign advance    = can_accept && !rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_i     (req_valid),
      .advance_i (advance),
      .ptr_i     (ptr_q),
      .grant_o   (req_ready),
      .idx_o     (win_idx)
   );

   assign xfer = |(req_valid & req_ready);

   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      sel_op  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == ID_W'(i)) begin
            sel_op1 = req_op1[i*XLEN +: XLEN];
            sel_op2 = req_op2[i*XLEN +: XLEN];
            sel_op  = req_aluop[i*4 +: 4];
         end
      end
   end

   assign shamt = sel_op2[4:0];

   alu_core #(
      .XLEN (XLEN)
   ) u_alu (
      .a_i      (sel_op1),
      .b_i      (sel_op2),
      .shamt_i  (shamt),
      .op_i     (sel_op),
      .result_o (alu_result)
   );

   always_comb begin
      ptr_d         = ptr_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      if (xfer) begin
         ptr_d         = win_idx;
         resp_valid_d  = 1'b1;
         resp_id_d     = win_idx;
         resp_result_d = alu_result;
      end else if (resp_ready) begin
         resp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q         <= ID_W'(NUM_REQ - 1);
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
      end else begin
         ptr_q         <= ptr_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;

`ifdef ALU_ARBITER_ERR_EN
   logic resp_err_q, resp_err_d;

   always_comb begin
      resp_err_d = resp_err_q;
      if (xfer) begin
         resp_err_d = !is_legal_op(sel_op);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_err_q <= 1'b0;
      end else begin
         resp_err_q <= resp_err_d;
      end
   end

   assign resp_err = resp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int N  = 2;
   localparam int XL = 32;
   localparam int IW = 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*XL-1:0] req_op1 = '0;
   logic [N*XL-1:0] req_op2 = '0;
   logic [N*4-1:0]  req_aluop = '0;
   logic            resp_valid;
   logic            resp_ready = 1'b0;
   logic [IW-1:0]   resp_id;
   logic [XL-1:0]   resp_result;
`ifdef ALU_ARBITER_ERR_EN
   logic            resp_err;
`endif

   alu_arbiter #(.NUM_REQ(N), .XLEN(XL), .ID_W(IW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op1     (req_op1),
      .req_op2     (req_op2),
      .req_aluop   (req_aluop),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result)
`ifdef ALU_ARBITER_ERR_EN
      ,
      .resp_err    (resp_err)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: occupancy of the response slot and last grant.
   bit          m_valid  = 1'b0;
   int          m_id     = 0;
   logic [31:0] m_res    = '0;
   bit          m_err    = 1'b0;
   int          m_last   = N - 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      logic [31:0] r;
      sh = int'(b[4:0]);
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a | b;
         3: r = a ^ b;
         4: r = a & b;
         5: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         6: r = {31'd0, a < b};
         7: r = a << sh;
         8: r = a >> sh;
         9: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Per-cycle compare against the model, then advance the model by one edge.
   task automatic model_cmp();
      logic [N-1:0] exp_ready;
      int win;
      exp_ready = '0;
      win = -1;
      if (rst) begin
         chk("rst_ready", 64'(req_ready), 64'd0);
         chk("rst_valid", 64'(resp_valid), 64'd0);
         chk("rst_id", 64'(resp_id), 64'd0);
         chk("rst_result", 64'(resp_result), 64'd0);
         m_valid = 1'b0; m_id = 0; m_res = '0; m_err = 1'b0; m_last = N - 1;
      end else begin
         if (!m_valid || resp_ready) begin
            for (int k = 1; k <= N; k++) begin
               int j;
               j = (m_last + k) % N;
               if (win < 0 && req_valid[j]) win = j;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         chk("resp_valid", 64'(resp_valid), 64'(m_valid));
         if (m_valid) begin
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_result", 64'(resp_result), 64'(m_res));
`ifdef ALU_ARBITER_ERR_EN
            chk("resp_err", 64'(resp_err), 64'(m_err));
`endif
         end
         if (win >= 0) begin
            int op;
            op      = int'(req_aluop[win*4 +: 4]);
            m_valid = 1'b1;
            m_id    = win;
            m_res   = ref_alu(op, req_op1[win*XL +: XL], req_op2[win*XL +: XL]);
            m_err   = (op >= 10);
            m_last  = win;
         end else if (resp_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cmp();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
      req_op1[i*XL +: XL] = a;
      req_op2[i*XL +: XL] = b;
      req_aluop[i*4 +: 4] = 4'(op);
   endtask

   task automatic run_vec(input string name, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit exp_err);
      req_valid = 2'b01;
      set_req(0, op, a, b);
      step();
      #1;
      chk(name, 64'(resp_result), 64'(exp));
`ifdef ALU_ARBITER_ERR_EN
      chk({name, "_err"}, 64'(resp_err), 64'(exp_err));
`else
      if (exp_err) begin end
`endif
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   logic [31:0] held;

   initial begin
      // Reset state
      repeat (3) step();
      #1;
      chk("reset_ready", 64'(req_ready), 64'd0);
      chk("reset_valid", 64'(resp_valid), 64'd0);

      // First transaction: add 5+7 from requester 0
      rst = 1'b0;
      resp_ready = 1'b1;
      req_valid = 2'b01;
      set_req(0, 0, 32'd5, 32'd7);
      #1;
      chk("first_ready", 64'(req_ready), 64'b01);
      step();
      req_valid = 2'b00;
      #1;
      chk("first_valid", 64'(resp_valid), 64'd1);
      chk("first_id", 64'(resp_id), 64'd0);
      chk("first_result", 64'(resp_result), 64'd12);
      step();

      // Both requesters continuously: pointer is at 0, so 1 goes first
      req_valid = 2'b11;
      set_req(0, 1, 32'd3, 32'd5);
      set_req(1, 5, 32'hFFFF_FFFF, 32'd1);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("alt_ready", 64'(req_ready), (k % 2 == 0) ? 64'b10 : 64'b01);
         if (k > 0) begin
            chk("alt_valid", 64'(resp_valid), 64'd1);
            chk("alt_result", 64'(resp_result), (k % 2 == 1) ? 64'd1 : 64'hFFFF_FFFE);
         end
         step();
      end

      // Backpressure: last grant was requester 0 (3-5)
      resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 64'(req_ready), 64'd0);
         chk("bp_id", 64'(resp_id), 64'd0);
         chk("bp_result", 64'(resp_result), 64'hFFFF_FFFE);
         step();
      end
      resp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'b10);
      step();

      // Directed ALU corner cases from requester 0 alone
      req_valid = 2'b00;
      step();
      run_vec("sra", 9, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0);
      run_vec("sll", 7, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
      run_vec("sltu", 6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      run_vec("illegal", 12, 32'h1234_5678, 32'h9, 32'd0, 1'b1);
      run_vec("add_noerr", 0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);

      // Randomized traffic checked by the model every cycle
      for (int c = 0; c < 400; c++) begin
         req_valid  = 2'($urandom_range(0, 3));
         resp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            set_req(i, $urandom_range(0, 11), pick_operand(), pick_operand());
         end
         step();
      end

      // Reset while a response is pending
      req_valid  = 2'b11;
      resp_ready = 1'b0;
      set_req(0, 2, 32'hF0, 32'h0F);
      set_req(1, 3, 32'hFF, 32'h0F);
      step();
      step();
      #1;
      held = resp_result;
      chk("pre_reset_valid", 64'(resp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_reset_valid", 64'(resp_valid), 64'd0);
      chk("async_reset_ready", 64'(req_ready), 64'd0);
      step();
      step();
      rst = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("post_reset_ready", 64'(req_ready), 64'b01);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
